// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined chunk adder: mode encoding and
// pipeline depth derivation.
package adder_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // One register stage per CHUNK-bit slice of the carry chain.
    function automatic int unsigned calc_stages(int unsigned width, int unsigned chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from 1-bit full adders; also
// exposes the carry into the top bit so the caller can derive signed overflow.
module chunk_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb_in
);

    logic carry;

    always_comb begin
        carry    = c_in;
        sum      = '0;
        c_msb_in = 1'b0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb_in = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end

endmodule

// File: rtl/pipelined_chunk_adder.sv
// WIDTH-bit add/subtract unit with the carry chain cut into CHUNK-bit slices,
// one register stage per slice, on a valid/ready stream with global stall.
module pipelined_chunk_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);

    if (((WIDTH % CHUNK) != 0) || (WIDTH < CHUNK)) begin : g_bad_params
        $error("WIDTH must be a non-zero multiple of CHUNK");
    end

    logic             adv_c;
    logic [WIDTH-1:0] b_eff_c;
    logic             cin_eff_c;

    // Per-stage registers: a_q/b_q hold the not-yet-used upper chunks shifted
    // down so the next chunk to add always sits in the low CHUNK bits.
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             v_q   [STAGES];
    logic             v_d   [STAGES];
    logic             cy_q  [STAGES];
    logic             cy_d  [STAGES];
    logic             ovf_q [STAGES];
    logic             ovf_d [STAGES];

    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_v [STAGES];
    logic             src_c [STAGES];

    logic [CHUNK-1:0] ch_sum  [STAGES];
    logic             ch_cout [STAGES];
    logic             ch_cmsb [STAGES];

    assign adv_c     = !v_q[STAGES-1] || out_ready;
    assign b_eff_c   = (mode_e'(sub) == MODE_SUB) ? ~b : b;
    assign cin_eff_c = (mode_e'(sub) == MODE_SUB) ? 1'b1 : c_in;

    // What each stage would load: stage 0 from the port, others from the stage below.
    always_comb begin
        src_a[0] = a;
        src_b[0] = b_eff_c;
        src_s[0] = '0;
        src_v[0] = in_valid;
        src_c[0] = cin_eff_c;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_v[k] = v_q[k-1];
            src_c[k] = cy_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        chunk_adder #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .a       (src_a[k][CHUNK-1:0]),
            .b       (src_b[k][CHUNK-1:0]),
            .c_in    (src_c[k]),
            .sum     (ch_sum[k]),
            .c_out   (ch_cout[k]),
            .c_msb_in(ch_cmsb[k])
        );
    end

    // Bubbles advance only their valid bit; data registers load on valid slots.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            s_d[k]   = s_q[k];
            v_d[k]   = v_q[k];
            cy_d[k]  = cy_q[k];
            ovf_d[k] = ovf_q[k];
        end
        if (adv_c) begin
            for (int k = 0; k < STAGES; k++) begin
                v_d[k] = src_v[k];
                if (src_v[k]) begin
                    a_d[k]                   = src_a[k] >> CHUNK;
                    b_d[k]                   = src_b[k] >> CHUNK;
                    s_d[k]                   = src_s[k];
                    s_d[k][k*CHUNK +: CHUNK] = ch_sum[k];
                    cy_d[k]                  = ch_cout[k];
                    ovf_d[k]                 = ch_cout[k] ^ ch_cmsb[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                v_q[k]   <= 1'b0;
                cy_q[k]  <= 1'b0;
                ovf_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                v_q[k]   <= v_d[k];
                cy_q[k]  <= cy_d[k];
                ovf_q[k] <= ovf_d[k];
            end
        end
    end

    assign in_ready  = adv_c;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign c_out     = cy_q[STAGES-1];
    assign ovf       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Self-checking bench for pipelined_chunk_adder (WIDTH=16, CHUNK=4): directed
// corner cases plus random streaming against an arithmetic reference model.
module tb_pipelined_chunk_adder;

    localparam int unsigned W  = 16;
    localparam int unsigned CH = 4;
    localparam int unsigned ST = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         ovf;
        int           acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_cons = 0;
    bit   check_lat = 1'b1;

    pipelined_chunk_adder #(
        .WIDTH(W),
        .CHUNK(CH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(logic [W-1:0] xa, logic [W-1:0] xb, logic ci, logic sb);
        exp_t        e;
        int unsigned r;
        int          sa;
        int          sbv;
        int          sr;
        sa  = int'($signed(xa));
        sbv = int'($signed(xb));
        if (sb) begin
            r     = 32'(xa) - 32'(xb);
            e.sum = r[W-1:0];
            e.c   = (xa >= xb);
            sr    = sa - sbv;
        end else begin
            r     = 32'(xa) + 32'(xb) + 32'(ci);
            e.sum = r[W-1:0];
            e.c   = r[W];
            sr    = sa + sbv + int'(ci);
        end
        e.ovf     = (sr > 32767) || (sr < -32768);
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample handshake at the negedge, score it, then advance one clock.
    task automatic cycle(output logic acc);
        exp_t e;
        logic cons;
        acc  = in_valid && in_ready;
        cons = out_valid && out_ready;
        if (cons) begin
            n_cons++;
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("c_out", 32'(c_out), 32'(e.c));
                check("ovf", 32'(ovf), 32'(e.ovf));
                if (check_lat) check("latency", 32'(cyc - e.acc_cyc), 32'(ST));
            end
        end
        if (acc) begin
            e         = model(a, b, c_in, sub);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int max_cyc);
        logic acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < max_cyc && exp_q.size() > 0; n++) cycle(acc);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) cycle(acc);
    endtask

    task automatic send_one(input logic [W-1:0] xa, input logic [W-1:0] xb,
                            input logic ci, input logic sb);
        logic acc;
        a = xa; b = xb; c_in = ci; sub = sb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle(acc);
        check("directed_accept", 32'(acc), 32'd1);
        drain(12);
    endtask

    initial begin
        logic acc;
        logic have;
        int   sent;
        int   t;
        int   cons0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        send_one(16'h1234, 16'h0FCC, 1'b1, 1'b0);
        send_one(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send_one(16'h0005, 16'h0007, 1'b1, 1'b1);
        send_one(16'h8000, 16'h0001, 1'b0, 1'b1);
        send_one(16'h8000, 16'h8000, 1'b0, 1'b0);

        // Streaming with backpressure on cycles 6..9.
        check_lat = 1'b0;
        sent  = 0;
        t     = 0;
        have  = 1'b0;
        cons0 = n_cons;
        while (sent < 20 && t < 200) begin
            if (!have) begin
                a    = W'($urandom);
                b    = W'($urandom);
                c_in = 1'($urandom);
                sub  = 1'($urandom);
            end
            in_valid  = 1'b1;
            out_ready = !(t >= 6 && t <= 9);
            #1;
            if (t >= 6 && t <= 9) begin
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                if (exp_q.size() > 0) check("stall_sum", 32'(sum), 32'(exp_q[0].sum));
            end
            cycle(acc);
            have = !acc;
            if (acc) sent++;
            t++;
        end
        check("stream_sent", 32'(sent), 32'd20);
        drain(40);
        check("stream_count", 32'(n_cons - cons0), 32'd20);
        check_lat = 1'b1;

        // Bubbles: valid 1,0,1,0 reappears four cycles later.
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            in_valid = (j < 4) && (j % 2 == 0);
            a    = W'($urandom);
            b    = W'($urandom);
            c_in = 1'($urandom);
            sub  = 1'($urandom);
            if (j >= 4) check("bubble_out_valid", 32'(out_valid), 32'(j % 2 == 0));
            cycle(acc);
        end
        drain(12);

        // Reset with three beats in flight.
        for (int j = 0; j < 3; j++) begin
            a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            cycle(acc);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        a = 16'hA5A5; b = 16'h5A5B; c_in = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        cycle(acc);
        check("midrst_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("midrst_quiet", 32'(out_valid), 32'd0);
            cycle(acc);
        end
        check("midrst_result_valid", 32'(out_valid), 32'd1);
        drain(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
